pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Multi-cycle fetch sequencer that owns the program counter and drives instruction fetch in the single-cycle datapath. It issues one instruction-memory request at a time and presents the fetched word to decode with a valid/ready handshake. When decode accepts the word, the sequencer computes the next PC from the branch/jump resolution inputs. It replaces free-running PC increment with a controlled fetch, so memory wait states, decode back-pressure and halt are handled in one place.

## Interface
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_addr  out  32  fetch address; equals current PC
- imem_rsp_valid  in  1  read data valid
- imem_rdata  in  32  read data
- instr_valid  out  1  fetched instruction available to decode
- instr_ready  in  1  decode accepts instruction
- instr  out  32  held instruction word
- instr_pc  out  32  PC of held instruction
- branch  in  1  taken branch for the held instruction; sampled on accept
- j  in  1  jump for the held instruction; sampled on accept; priority over branch
- imm32  in  32  sign-extended branch offset, in words
- target_addr  in  26  jump target
- halt  in  1  stop after the held instruction; sampled on accept
- halted  out  1  sequencer stopped
- retired  out  32  count of accepted instructions

## Operation
- States: BOOT, REQ, WAIT, HOLD, HALT. Every output is a Moore decode of state or a register.
- BOOT: entered on reset. No outputs asserted. PC = RESET_VECTOR. Moves to REQ on the next cycle.
- REQ: imem_req_valid=1, imem_addr=PC held stable. When imem_req_ready=1, moves to WAIT. imem_rsp_valid is ignored in REQ.
- WAIT: when imem_rsp_valid=1, captures imem_rdata into instr and PC into instr_pc, then moves to HOLD.
- HOLD: instr_valid=1; instr and instr_pc are stable until accepted. Accept means instr_valid && instr_ready. On accept:
  - retired increments.
  - If halt=1, moves to HALT and PC is unchanged.
  - Otherwise PC is updated as follows and the state moves to REQ:
    - j=1: PC ← {6'b000000, target_addr}
    - else branch=1: PC ← instr_pc + 4 + (imm32 << 2)
    - else: PC ← instr_pc + 4
- PC arithmetic is 32-bit modulo 2^32. Overflow wraps silently.
- j and branch asserted together resolve as a jump.
- HALT: halted=1. No requests are issued. The only exit is reset.
- retired wraps from 32'hFFFF_FFFF to 0.

## Timing
- Reset values: imem_req_valid=0, instr_valid=0, halted=0, instr=0, instr_pc=0, retired=0, imem_addr=RESET_VECTOR.
- When rst_n is low at a rising edge, the sequencer enters BOOT regardless of current state. Any response still in flight is dropped; the memory shares rst_n.
- First request: imem_req_valid rises in the second cycle after rst_n is sampled high (BOOT lasts one cycle).
- Minimum cost per instruction is 3 cycles: REQ accepted in cycle 0, response in cycle 1, accept in cycle 2. The next REQ asserts in cycle 3.
- The redirected address appears on imem_addr in the cycle after accept. There is no speculative fetch and nothing to flush.
- branch, j, imm32, target_addr and halt are don't-care outside accept cycles.

## Structure
- Shared package holds:
  - the state enum (BOOT, REQ, WAIT, HOLD, HALT)
  - the INSTR_BYTES=4 constant
  - the jump-target formation function `{6'b0, target}`, so the datapath and the sequencer agree
- One combinational sub-module, pc_next_calc, takes instr_pc, imm32, target_addr, branch and j and returns the next PC. The FSM, PC register and counters stay in pc_sequencer.

## Test plan
- Reset and sequential fetch: hold rst_n low for 3 cycles with a zero-wait memory and instr_ready=1, no branches. Required: addresses 0x0, 0x4, 0x8; retired=3 after the third accept; a new request every 3 cycles.
- Branch: instr_pc=0x10, branch=1, imm32=32'hFFFF_FFFE on accept. Required: next imem_addr=0x0C. With imm32=3, required: 0x20.
- Jump priority: j=1 and branch=1, target_addr=26'h40 on accept. Required: next imem_addr=0x40.
- Back-pressure and wait states: imem_req_ready low for 4 cycles, then response 2 cycles later, then instr_ready low for 5 cycles. Required:
  - imem_addr stable while ready is low.
  - instr and instr_pc stable while instr_ready is low.
  - Exactly one retire.
- Halt, and reset mid-operation:
  - Accept with halt=1. Required: halted=1, no further imem_req_valid, retired frozen.
  - Then assert rst_n low while in WAIT. Required: BOOT, then a request at RESET_VECTOR, with retired=0.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: shared fetch-sequencer types, constants and jump-target formation
package pc_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_REQ,
        ST_WAIT,
        ST_HOLD,
        ST_HALT
    } state_t;

    localparam logic [31:0] INSTR_BYTES = 32'd4;

    function automatic logic [31:0] jump_target(input logic [25:0] target);
        return {6'b000000, target};
    endfunction

endpackage

// File: rtl/pc_next_calc.sv
// pc_next_calc: next-PC resolution for an accepted instruction; jump wins over branch
module pc_next_calc
    import pc_sequencer_pkg::*;
(
    input  logic [31:0] i_instr_pc,
    input  logic [31:0] i_imm32,
    input  logic [25:0] i_target_addr,
    input  logic        i_branch,
    input  logic        i_j,
    output logic [31:0] o_next_pc
);

    logic [31:0] w_seq_pc;
    logic [31:0] w_br_pc;

    assign w_seq_pc  = i_instr_pc + INSTR_BYTES;
    // imm32 counts words, so scale to bytes before adding
    assign w_br_pc   = w_seq_pc + {i_imm32[29:0], 2'b00};
    assign o_next_pc = i_j ? jump_target(i_target_addr) : (i_branch ? w_br_pc : w_seq_pc);

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: single-outstanding instruction fetch sequencer owning the PC
// Moore outputs from a BOOT/REQ/WAIT/HOLD/HALT FSM; PC redirects on decode accept.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        branch,
    input  logic        j,
    input  logic [31:0] imm32,
    input  logic [25:0] target_addr,
    input  logic        halt,
    output logic        halted,
    output logic [31:0] retired
);

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_instr_pc;
    logic [31:0] r_retired;
    logic [31:0] w_next_pc;
    logic        w_accept;

    assign w_accept = (r_state == ST_HOLD) && instr_ready;

    pc_next_calc u_pc_next_calc (
        .i_instr_pc   (r_instr_pc),
        .i_imm32      (imm32),
        .i_target_addr(target_addr),
        .i_branch     (branch),
        .i_j          (j),
        .o_next_pc    (w_next_pc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_state <= ST_BOOT;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_BOOT: w_next_state = ST_REQ;
            ST_REQ:  w_next_state = imem_req_ready ? ST_WAIT : ST_REQ;
            ST_WAIT: w_next_state = imem_rsp_valid ? ST_HOLD : ST_WAIT;
            ST_HOLD: w_next_state = w_accept ? (halt ? ST_HALT : ST_REQ) : ST_HOLD;
            ST_HALT: w_next_state = ST_HALT;
            default: w_next_state = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc       <= RESET_VECTOR;
            r_instr    <= '0;
            r_instr_pc <= '0;
            r_retired  <= '0;
        end else begin
            if (r_state == ST_WAIT && imem_rsp_valid) begin
                r_instr    <= imem_rdata;
                r_instr_pc <= r_pc;
            end
            if (w_accept) begin
                r_retired <= r_retired + 32'd1;
                // a halting instruction leaves the PC pointing at itself
                if (!halt)
                    r_pc <= w_next_pc;
            end
        end
    end

    assign imem_req_valid = (r_state == ST_REQ);
    assign instr_valid    = (r_state == ST_HOLD);
    assign halted         = (r_state == ST_HALT);
    assign imem_addr      = r_pc;
    assign instr          = r_instr;
    assign instr_pc       = r_instr_pc;
    assign retired        = r_retired;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: drives fetch/decode handshakes and checks against a PC/retire model
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        branch = 1'b0;
    logic        j = 1'b0;
    logic [31:0] imm32 = '0;
    logic [25:0] target_addr = '0;
    logic        halt = 1'b0;
    logic        halted;
    logic [31:0] retired;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          req_cyc = 0;
    logic [31:0] m_pc = 32'h0;
    logic [31:0] m_ret = 32'h0;

    pc_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_addr     (imem_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rdata    (imem_rdata),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .branch        (branch),
        .j             (j),
        .imm32         (imm32),
        .target_addr   (target_addr),
        .halt          (halt),
        .halted        (halted),
        .retired       (retired)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full instruction round trip with the given wait states and resolution inputs.
    task automatic fetch_one(input int rq, input int rs, input int ac, input logic br, input logic jj,
                             input logic [31:0] imm, input logic [25:0] tgt, input logic hl);
        int          n;
        logic [31:0] data;
        n = 0;
        while (!imem_req_valid && n < 10) begin
            step();
            n++;
        end
        checks++;
        if (imem_req_valid !== 1'b1) begin
            $display("FAIL req_timeout: imem_req_valid=%b required 1", imem_req_valid);
            errors++;
        end
        req_cyc = cyc;
        checks++;
        if (imem_addr !== m_pc) begin
            $display("FAIL req_addr: imem_addr=%h required %h", imem_addr, m_pc);
            errors++;
        end
        for (int k = 0; k < rq; k++) begin
            imem_req_ready = 1'b0;
            imem_rsp_valid = $urandom_range(0, 1);
            step();
            checks++;
            if (imem_req_valid !== 1'b1 || imem_addr !== m_pc) begin
                $display("FAIL req_stall: valid=%b addr=%h required 1 %h", imem_req_valid, imem_addr, m_pc);
                errors++;
            end
        end
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        checks++;
        if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin
            $display("FAIL wait_state: req_valid=%b instr_valid=%b required 0 0", imem_req_valid, instr_valid);
            errors++;
        end
        for (int k = 0; k < rs; k++) step();
        data = $urandom;
        imem_rsp_valid = 1'b1;
        imem_rdata = data;
        step();
        imem_rsp_valid = 1'b0;
        imem_rdata = $urandom;
        checks++;
        if (instr_valid !== 1'b1 || instr !== data || instr_pc !== m_pc) begin
            $display("FAIL hold: valid=%b instr=%h pc=%h required 1 %h %h", instr_valid, instr, instr_pc, data, m_pc);
            errors++;
        end
        for (int k = 0; k < ac; k++) begin
            instr_ready = 1'b0;
            branch = $urandom_range(0, 1);
            j = $urandom_range(0, 1);
            halt = $urandom_range(0, 1);
            imm32 = $urandom;
            target_addr = 26'($urandom);
            step();
            checks++;
            if (instr_valid !== 1'b1 || instr !== data || instr_pc !== m_pc || retired !== m_ret) begin
                $display("FAIL decode_stall: valid=%b instr=%h pc=%h ret=%0d required 1 %h %h %0d",
                         instr_valid, instr, instr_pc, retired, data, m_pc, m_ret);
                errors++;
            end
        end
        instr_ready = 1'b1;
        branch = br;
        j = jj;
        imm32 = imm;
        target_addr = tgt;
        halt = hl;
        step();
        instr_ready = 1'b0;
        branch = $urandom_range(0, 1);
        j = $urandom_range(0, 1);
        halt = $urandom_range(0, 1);
        m_ret = m_ret + 1;
        if (!hl)
            m_pc = jj ? {6'd0, tgt} : m_pc + 4 + (br ? imm * 4 : 32'd0);
        checks++;
        if (retired !== m_ret || halted !== hl || imem_req_valid !== !hl || imem_addr !== m_pc) begin
            $display("FAIL accept: ret=%0d halted=%b req=%b addr=%h required %0d %b %b %h",
                     retired, halted, imem_req_valid, imem_addr, m_ret, hl, !hl, m_pc);
            errors++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        step();
        checks++;
        if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0 || halted !== 1'b0 || instr !== 32'h0 ||
            instr_pc !== 32'h0 || retired !== 32'h0 || imem_addr !== 32'h0) begin
            $display("FAIL reset_values: req=%b iv=%b halted=%b instr=%h pc=%h ret=%0d addr=%h required all zero",
                     imem_req_valid, instr_valid, halted, instr, instr_pc, retired, imem_addr);
            errors++;
        end
        rst_n = 1'b1;
        checks++;
        if (imem_req_valid !== 1'b0) begin
            $display("FAIL boot: imem_req_valid=%b required 0", imem_req_valid);
            errors++;
        end
        step();
        checks++;
        if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin
            $display("FAIL first_req: valid=%b addr=%h required 1 00000000", imem_req_valid, imem_addr);
            errors++;
        end
        m_pc = 32'h0;
        m_ret = 32'h0;
    endtask

    task automatic test_sequential();
        int prev;
        logic [31:0] exp_addr;
        for (int i = 0; i < 3; i++) begin
            exp_addr = 32'(i * 4);
            checks++;
            if (imem_addr !== exp_addr) begin
                $display("FAIL seq_addr%0d: imem_addr=%h required %h", i, imem_addr, exp_addr);
                errors++;
            end
            prev = req_cyc;
            fetch_one(0, 0, 0, 1'b0, 1'b0, 32'h0, 26'h0, 1'b0);
            if (i > 0) begin
                checks++;
                if (req_cyc - prev != 3) begin
                    $display("FAIL seq_period: %0d cycles required 3", req_cyc - prev);
                    errors++;
                end
            end
        end
        checks++;
        if (retired !== 32'd3) begin
            $display("FAIL seq_retired: retired=%0d required 3", retired);
            errors++;
        end
    endtask

    task automatic test_branch();
        fetch_one(0, 0, 0, 1'b0, 1'b0, 32'h0, 26'h0, 1'b0);
        fetch_one(0, 0, 0, 1'b1, 1'b0, 32'hFFFF_FFFE, 26'h0, 1'b0);
        checks++;
        if (imem_addr !== 32'h0C) begin
            $display("FAIL branch_back: imem_addr=%h required 0000000c", imem_addr);
            errors++;
        end
        fetch_one(0, 0, 0, 1'b0, 1'b0, 32'h0, 26'h0, 1'b0);
        fetch_one(0, 0, 0, 1'b1, 1'b0, 32'd3, 26'h0, 1'b0);
        checks++;
        if (imem_addr !== 32'h20) begin
            $display("FAIL branch_fwd: imem_addr=%h required 00000020", imem_addr);
            errors++;
        end
    endtask

    task automatic test_jump();
        fetch_one(0, 0, 0, 1'b1, 1'b1, 32'h0000_0100, 26'h40, 1'b0);
        checks++;
        if (imem_addr !== 32'h40) begin
            $display("FAIL jump_prio: imem_addr=%h required 00000040", imem_addr);
            errors++;
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] r0;
        r0 = m_ret;
        fetch_one(4, 2, 5, 1'b0, 1'b0, 32'h0, 26'h0, 1'b0);
        checks++;
        if (retired !== r0 + 1) begin
            $display("FAIL bp_retire: retired=%0d required %0d", retired, r0 + 1);
            errors++;
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 30; i++)
            fetch_one($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), $urandom,
                      26'($urandom), 1'b0);
    endtask

    task automatic test_halt_reset();
        fetch_one(1, 1, 1, 1'b0, 1'b0, 32'h0, 26'h0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            imem_req_ready = 1'b1;
            instr_ready = 1'b1;
            step();
            checks++;
            if (imem_req_valid !== 1'b0 || halted !== 1'b1 || retired !== m_ret) begin
                $display("FAIL halted_idle: req=%b halted=%b ret=%0d required 0 1 %0d",
                         imem_req_valid, halted, retired, m_ret);
                errors++;
            end
        end
        imem_req_ready = 1'b0;
        instr_ready = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        m_pc = 32'h0;
        m_ret = 32'h0;
        checks++;
        if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0 || halted !== 1'b0) begin
            $display("FAIL halt_exit: req=%b addr=%h halted=%b required 1 00000000 0", imem_req_valid, imem_addr, halted);
            errors++;
        end
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        rst_n = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_rsp_valid = 1'b0;
        checks++;
        if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0 || retired !== 32'h0 || instr !== 32'h0 ||
            imem_addr !== 32'h0) begin
            $display("FAIL wait_reset: req=%b iv=%b ret=%0d instr=%h addr=%h required 0 0 0 0 0",
                     imem_req_valid, instr_valid, retired, instr, imem_addr);
            errors++;
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0 || retired !== 32'h0) begin
            $display("FAIL reboot_req: req=%b addr=%h ret=%0d required 1 00000000 0", imem_req_valid, imem_addr, retired);
            errors++;
        end
        fetch_one(0, 0, 0, 1'b0, 1'b0, 32'h0, 26'h0, 1'b0);
    endtask

    initial begin
        #1;
        test_reset();
        test_sequential();
        test_branch();
        test_jump();
        test_backpressure();
        test_back_to_back();
        test_halt_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
